// File: rtl/uart_defs.sv
// ============================================================================
// Module  : uart_defs
// Purpose : Shared 8N1 framing constants and receiver state encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package uart_defs;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchroniser for an asynchronous single-bit input.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module  : uart_receiver
// Purpose : 8N1 UART receive path with Valid/Ack holding register and errors.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  input  logic                 Ack,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Valid,
  output logic                 Frame_Err,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (RX),
    .q_o    (rx_s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (valid_q && Ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          state_d = rx_s ? ST_IDLE : ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          if (rx_s) begin
            // A same-cycle Ack frees the register, so only an unacked byte overruns.
            data_d  = shift_q;
            valid_d = 1'b1;
            ov_d    = valid_q && !Ack;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign Data      = data_q;
  assign Valid     = valid_q;
  assign Frame_Err = fe_q;
  assign Overrun   = ov_q;
  assign Busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module  : tb_uart_receiver
// Purpose : Directed self-checking bench for uart_receiver (CLKS_PER_BIT=16).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int C = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX  = 1'b1;
  logic       Ack = 1'b0;
  logic [7:0] Data;
  logic       Valid;
  logic       Frame_Err;
  logic       Overrun;
  logic       Busy;

  uart_receiver #(
    .CLKS_PER_BIT (C)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX        (RX),
    .Ack       (Ack),
    .Data      (Data),
    .Valid     (Valid),
    .Frame_Err (Frame_Err),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Event recorder: cycle numbers are those of the posedge just before sampling.
  int   v_rise = -1, b_rise = -1, b_fall = -1, fe_at = -1, ov_at = -1;
  int   fe_n = 0, ov_n = 0;
  logic v_prev = 1'b0, b_prev = 1'b0;
  always @(negedge CLK) begin
    if (Valid && !v_prev) v_rise = cyc;
    if (Busy && !b_prev)  b_rise = cyc;
    if (!Busy && b_prev)  b_fall = cyc;
    if (Frame_Err) begin fe_n++; fe_at = cyc; end
    if (Overrun)   begin ov_n++; ov_at = cyc; end
    v_prev = Valid;
    b_prev = Busy;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; tf is the cycle count at the RX falling edge.
  task automatic send_frame(input logic [7:0] b, input int stop_low, output int tf);
    tf = cyc;
    RX = 1'b0;
    repeat (C) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (C) @(negedge CLK);
    end
    if (stop_low > 0) begin
      RX = 1'b0;
      repeat (stop_low) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (C) @(negedge CLK);
  endtask

  task automatic ack_pulse();
    Ack = 1'b1;
    @(negedge CLK);
    Ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    int         stop_low;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_bfall;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int tf, tf2, fe0, ov0, vr;

    vecs[0] = '{8'h55, 0,  8'h55, 1'b1, 0, 155};
    vecs[1] = '{8'h00, 0,  8'h00, 1'b1, 0, 155};
    vecs[2] = '{8'hFF, 0,  8'hFF, 1'b1, 0, 155};
    vecs[3] = '{8'hA3, 40, 8'hFF, 1'b0, 1, 187};
    vecs[4] = '{8'h01, 0,  8'h01, 1'b1, 0, 155};
    vecs[5] = '{8'h80, 0,  8'h80, 1'b1, 0, 155};
    vecs[6] = '{8'hC5, 12, 8'h80, 1'b0, 1, 159};

    repeat (3) @(negedge CLK);
    check("reset Data", 32'(Data), 32'h0);
    check("reset Valid", 32'(Valid), 32'h0);
    check("reset Busy", 32'(Busy), 32'h0);
    check("reset Frame_Err", 32'(Frame_Err), 32'h0);
    check("reset Overrun", 32'(Overrun), 32'h0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      fe0 = fe_n;
      ov0 = ov_n;
      send_frame(vecs[i].tx, vecs[i].stop_low, tf);
      check($sformatf("v%0d Data", i), 32'(Data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d Valid", i), 32'(Valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d Frame_Err count", i), 32'(fe_n - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d Overrun count", i), 32'(ov_n - ov0), 32'h0);
      check($sformatf("v%0d Busy fall", i), 32'(b_fall - tf), 32'(vecs[i].exp_bfall));
      if (vecs[i].exp_valid)
        check($sformatf("v%0d Valid rise", i), 32'(v_rise - tf), 32'd155);
      else
        check($sformatf("v%0d Frame_Err time", i), 32'(fe_at - tf), 32'd155);
      ack_pulse();
      check($sformatf("v%0d Valid after Ack", i), 32'(Valid), 32'h0);
      repeat (4) @(negedge CLK);
    end

    // Short low glitch: START aborts at mid start bit.
    fe0 = fe_n;
    tf = cyc;
    RX = 1'b0;
    repeat (3) @(negedge CLK);
    RX = 1'b1;
    repeat (20) @(negedge CLK);
    check("glitch Busy rise", 32'(b_rise - tf), 32'd3);
    check("glitch Busy fall", 32'(b_fall - tf), 32'd11);
    check("glitch Valid", 32'(Valid), 32'h0);
    check("glitch Frame_Err count", 32'(fe_n - fe0), 32'h0);

    // Back-to-back frames without Ack: one overrun at the second stop sample.
    fe0 = fe_n;
    ov0 = ov_n;
    send_frame(8'h12, 0, tf);
    send_frame(8'h34, 0, tf2);
    check("b2b tf2", 32'(tf2 - tf), 32'd160);
    check("b2b Data", 32'(Data), 32'h34);
    check("b2b Valid", 32'(Valid), 32'h1);
    check("b2b Overrun count", 32'(ov_n - ov0), 32'h1);
    check("b2b Overrun time", 32'(ov_at - tf2), 32'd155);
    check("b2b Frame_Err count", 32'(fe_n - fe0), 32'h0);
    ack_pulse();
    repeat (4) @(negedge CLK);

    // Ack on the same cycle the next byte completes: no overrun.
    send_frame(8'h7E, 0, tf);
    vr = v_rise;
    check("ack-coinc first rise", 32'(vr - tf), 32'd155);
    ov0 = ov_n;
    tf2 = cyc;
    fork
      send_frame(8'h81, 0, tf);
      begin
        while (cyc != tf2 + 154) @(negedge CLK);
        ack_pulse();
      end
    join
    check("ack-coinc Data", 32'(Data), 32'h81);
    check("ack-coinc Valid", 32'(Valid), 32'h1);
    check("ack-coinc Overrun count", 32'(ov_n - ov0), 32'h0);
    check("ack-coinc Valid held", 32'(v_rise), 32'(vr));

    // Reset during bit 4 of a frame, then a clean frame.
    fe0 = fe_n;
    ov0 = ov_n;
    fork
      send_frame(8'hC3, 0, tf);
      begin
        repeat (C + 4 * C + 8) @(negedge CLK);
        check("midframe Busy before reset", 32'(Busy), 32'h1);
        RST = 1'b0;
        #1;
        check("midreset Data", 32'(Data), 32'h0);
        check("midreset Valid", 32'(Valid), 32'h0);
        check("midreset Busy", 32'(Busy), 32'h0);
      end
    join
    check("midreset Frame_Err count", 32'(fe_n - fe0), 32'h0);
    check("midreset Overrun count", 32'(ov_n - ov0), 32'h0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    send_frame(8'h0F, 0, tf);
    check("post-reset Data", 32'(Data), 32'h0F);
    check("post-reset Valid", 32'(Valid), 32'h1);
    check("post-reset Valid rise", 32'(v_rise - tf), 32'd155);
    check("post-reset Frame_Err count", 32'(fe_n - fe0), 32'h0);
    check("post-reset Overrun count", 32'(ov_n - ov0), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive end of the board's 8N1 serial link: accepts frames from the UART transmitter that streams the encoder count, and recovers each byte.
- Input is asynchronous to CLK. The block synchronises it, qualifies the start bit, mid-bit samples 8 data bits LSB first, and checks the stop bit.
- Each byte is presented in a holding register with a Valid/Ack handshake. Framing and overrun errors are flagged.

Parameters:
- CLKS_PER_BIT, 5208, CLK cycles per bit period (50 MHz / 9600 baud); must be even and >= 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-low reset
- RX  input  1  serial line; idles high; asynchronous to CLK
- Ack  input  1  consumer has taken Data; meaningful only while Valid=1
- Data  output  8  last correctly framed byte
- Valid  output  1  Data holds an unconsumed byte
- Frame_Err  output  1  one-cycle pulse: stop bit sampled 0
- Overrun  output  1  one-cycle pulse: new byte overwrote an unconsumed byte
- Busy  output  1  receiver is inside a frame (state != IDLE)

Behaviour:
- Reset (RST=0, asynchronous):
  - Data=0, Valid=0, Frame_Err=0, Overrun=0, Busy=0.
  - Both synchroniser flops are set to 1 (line idle); state=IDLE; bit counter and index are 0.
  - Reset mid-frame abandons the frame; no pulse is generated.
- Synchroniser: 2-flop. rx_s follows RX with 2 cycles of latency. All decisions use rx_s only.
- Constants: C=CLKS_PER_BIT, H=C/2.
- Cycle counter cnt: cleared on every state change; otherwise increments each cycle.
- State IDLE: if rx_s=0 in cycle t0 -> START.
- State START: when cnt=H-1 (cycle t0+H), sample rx_s.
  - 0 -> DATA, bit index=0.
  - 1 -> IDLE; this is a glitch, no flags.
- State DATA: when cnt=C-1, sample rx_s into the shift register.
  - Shift right; new bit enters the MSB, so the first received bit ends at Data[0].
  - Bit k is sampled at cycle t0+H+(k+1)*C.
  - After bit 7 -> STOP.
- State STOP: when cnt=C-1 (cycle ts=t0+H+9C), sample rx_s.
  - 1: Data<=shift register and Valid<=1, both visible from ts+1. Then -> IDLE.
  - 0: Frame_Err=1 for cycle ts+1 only. Data and Valid are unchanged. Then -> BRK.
- State BRK: wait for rx_s=1, then -> IDLE. This prevents a held-low line (break) from retriggering.
- Handshake:
  - Valid stays high until a cycle with Ack=1 and Valid=1; Valid clears on the next edge.
  - Ack while Valid=0 is ignored.
- Simultaneous events:
  - Good stop bit while Valid=1 and Ack=0: Data is overwritten, Valid stays 1, Overrun pulses for 1 cycle.
  - Good stop bit in the same cycle as Ack=1: the new byte loads, Valid stays 1, no Overrun.
- Busy=1 in START, DATA, STOP and BRK.
- Frame end: the receiver returns to IDLE at mid-stop-bit, so back-to-back frames are received with no gap.

Decomposition:
- Shared package/include uart_defs: DATA_BITS=8, the default CLKS_PER_BIT, and the state encoding IDLE=0, START=1, DATA=2, STOP=3, BRK=4. The transmitter uses the same package so both ends agree on framing.
- One natural sub-module: sync_2ff (parameterised reset value, here 1). Reused for the encoder A/B inputs.
- Everything else stays in uart_receiver as a single FSM with cnt and a 3-bit index.

Test Plan (CLKS_PER_BIT=16, H=8; t0 = 2 cycles after the RX falling edge):
- Send 0x55, Ack held 0 -> Valid rises at t0+153, Data=0x55, Busy falls at the same edge, no error pulses.
- RX low for 3 cycles, then high -> START aborts at t0+8; Valid=0, Frame_Err=0, Busy high for 8 cycles only.
- Send 0xA3 with the stop bit driven 0 for 40 cycles -> Frame_Err pulse at t0+153, Data keeps its old value, Busy stays 1 until rx_s returns to 1.
- Send 0x12 then 0x34 back-to-back with no Ack -> Data=0x34, Valid=1, one Overrun pulse at the second stop sample.
- Send 0x7E, pulse Ack on the exact cycle the next byte 0x81 completes -> Data=0x81, Valid=1, Overrun=0.
- Assert RST during bit 4 of 0xC3, release, then send 0x0F -> all outputs 0 during reset, then Data=0x0F and Valid=1 with no error pulses.
